register_if_id_skid: RTL and testbench

Parametrised IF/ID pipeline stage register for the RISC-V core, sitting between the fetch unit and the decoder. It carries PC, instruction and branch-prediction bit across the stage with a valid/ready handshake. A two-entry skid buffer keeps `in_ready` a function of registered state only, so the ready path is never combinational from `out_ready`. It also supports synchronous flush with NOP insertion and provides saturating bubble/hold performance counters.

---
 rtl/register_if_id_skid.sv | 163 ++++++++++++++++
 tb/tb_register_if_id_skid.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/register_if_id_skid.sv
// register_if_id_skid
// IF/ID pipeline stage register with a two-entry skid buffer. The head
// register drives the decoder-facing outputs; the skid register catches the
// one entry that may arrive in the cycle ID stalls. in_ready depends only on
// registered state, so there is no combinational path from out_ready.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   in_valid / in_ready        fetch-side handshake
//   pc_in, instruction_in,
//   pred_taken_in              fetch-side payload
//   out_valid / out_ready      decode-side handshake
//   pc_out, pc_plus4_out,
//   instruction_out,
//   pred_taken_out             head entry (NOP / not-taken when empty)
//   flush                      drop held and incoming entries
//   cnt_clear                  clear both performance counters
//   bubble_count, hold_count   saturating stall counters
module register_if_id_skid #(
    parameter int                   DATA_BITS = 32,
    parameter logic [DATA_BITS-1:0] RESET_PC  = '0,
    parameter logic [DATA_BITS-1:0] NOP_INSTR = DATA_BITS'(32'h0000_0013),
    parameter int                   CNT_BITS  = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DATA_BITS-1:0] pc_in,
    input  logic [DATA_BITS-1:0] instruction_in,
    input  logic                 pred_taken_in,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATA_BITS-1:0] pc_out,
    output logic [DATA_BITS-1:0] pc_plus4_out,
    output logic [DATA_BITS-1:0] instruction_out,
    output logic                 pred_taken_out,
    input  logic                 flush,
    input  logic                 cnt_clear,
    output logic [CNT_BITS-1:0]  bubble_count,
    output logic [CNT_BITS-1:0]  hold_count
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;

    logic [DATA_BITS-1:0]  r_head_pc;
    logic [DATA_BITS-1:0]  r_head_instr;
    logic                  r_head_pred;
    logic [DATA_BITS-1:0]  r_skid_pc;
    logic [DATA_BITS-1:0]  r_skid_instr;
    logic                  r_skid_pred;
    logic [CNT_BITS-1:0]   r_bubble;
    logic [CNT_BITS-1:0]   r_hold;

    logic                  w_accept;
    logic                  w_deliver;
    logic                  w_load_head;
    logic                  w_head_from_skid;
    logic                  w_load_skid;

    assign in_ready  = (r_state != ST_TWO);
    assign out_valid = (r_state != ST_EMPTY);
    assign w_accept  = in_valid & in_ready;
    assign w_deliver = out_valid & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_EMPTY;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_load_head      = 1'b0;
        w_head_from_skid = 1'b0;
        w_load_skid      = 1'b0;
        case (r_state)
            ST_EMPTY: begin
                if (w_accept) begin
                    w_load_head = 1'b1;
                    w_state_nxt = ST_ONE;
                end
            end
            ST_ONE: begin
                if (w_accept && w_deliver) begin
                    w_load_head = 1'b1;
                end else if (w_accept) begin
                    w_load_skid = 1'b1;
                    w_state_nxt = ST_TWO;
                end else if (w_deliver) begin
                    w_state_nxt = ST_EMPTY;
                end
            end
            ST_TWO: begin
                if (w_deliver) begin
                    w_load_head      = 1'b1;
                    w_head_from_skid = 1'b1;
                    w_state_nxt      = ST_ONE;
                end
            end
            default: w_state_nxt = ST_EMPTY;
        endcase
        // Flush wins: nothing is written, so pc_out keeps the last head PC.
        if (flush) begin
            w_state_nxt      = ST_EMPTY;
            w_load_head      = 1'b0;
            w_head_from_skid = 1'b0;
            w_load_skid      = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head_pc    <= RESET_PC;
            r_head_instr <= NOP_INSTR;
            r_head_pred  <= 1'b0;
        end else if (w_load_head) begin
            r_head_pc    <= w_head_from_skid ? r_skid_pc    : pc_in;
            r_head_instr <= w_head_from_skid ? r_skid_instr : instruction_in;
            r_head_pred  <= w_head_from_skid ? r_skid_pred  : pred_taken_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_skid_pc    <= '0;
            r_skid_instr <= '0;
            r_skid_pred  <= 1'b0;
        end else if (w_load_skid) begin
            r_skid_pc    <= pc_in;
            r_skid_instr <= instruction_in;
            r_skid_pred  <= pred_taken_in;
        end
    end

    // Counters observe the handshake only; flush does not affect them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bubble <= '0;
            r_hold   <= '0;
        end else if (cnt_clear) begin
            r_bubble <= '0;
            r_hold   <= '0;
        end else begin
            if (!out_valid && out_ready && (r_bubble != '1)) r_bubble <= r_bubble + 1'b1;
            if (out_valid && !out_ready && (r_hold != '1))   r_hold   <= r_hold + 1'b1;
        end
    end

    assign pc_out          = r_head_pc;
    assign pc_plus4_out    = r_head_pc + DATA_BITS'(4);
    assign instruction_out = out_valid ? r_head_instr : NOP_INSTR;
    assign pred_taken_out  = out_valid & r_head_pred;
    assign bubble_count    = r_bubble;
    assign hold_count      = r_hold;

endmodule

// File: tb/tb_register_if_id_skid.sv
// Bench for register_if_id_skid. The reference model is a two-deep FIFO
// (SystemVerilog queue) plus two saturating counters. The driver pushes the
// expected entry when it offers an entry the model says will be accepted; the
// monitor on the falling edge checks the outputs against the queue head and
// pops whenever the model says ID consumes an entry.
module tb_register_if_id_skid;

    localparam int          DB   = 32;
    localparam int          CB   = 4;
    localparam logic [31:0] RPC  = 32'h0000_0080;
    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam int          MAXC = (1 << CB) - 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid, in_ready;
    logic [DB-1:0] pc_in, instruction_in;
    logic          pred_taken_in;
    logic          out_valid, out_ready;
    logic [DB-1:0] pc_out, pc_plus4_out, instruction_out;
    logic          pred_taken_out;
    logic          flush, cnt_clear;
    logic [CB-1:0] bubble_count, hold_count;

    register_if_id_skid #(
        .DATA_BITS(DB), .RESET_PC(RPC), .NOP_INSTR(NOP), .CNT_BITS(CB)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .pc_in(pc_in), .instruction_in(instruction_in), .pred_taken_in(pred_taken_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .pc_out(pc_out), .pc_plus4_out(pc_plus4_out),
        .instruction_out(instruction_out), .pred_taken_out(pred_taken_out),
        .flush(flush), .cnt_clear(cnt_clear),
        .bubble_count(bubble_count), .hold_count(hold_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ins;
        logic        pred;
    } ent_t;

    ent_t        q[$];
    bit          pend;
    int          m_bub, m_hold;
    logic [31:0] last_pc;
    logic [31:0] next_pc;
    int          n_cmp  = 0;
    int          n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h, expected %h", nm, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        pend    = 1'b0;
        m_bub   = 0;
        m_hold  = 0;
        last_pc = RPC;
    endtask

    // One cycle of stimulus, applied just after the rising edge.
    task automatic cyc(input bit v, input bit ordy, input bit fl, input bit clr);
        ent_t e;
        @(posedge clk);
        #1;
        e.pc           = next_pc;
        e.ins          = $urandom;
        e.pred         = 1'($urandom_range(0, 1));
        in_valid       = v;
        pc_in          = e.pc;
        instruction_in = e.ins;
        pred_taken_in  = e.pred;
        out_ready      = ordy;
        flush          = fl;
        cnt_clear      = clr;
        if (v && q.size() < 2 && !fl) begin
            q.push_back(e);
            pend    = 1'b1;
            next_pc = next_pc + 32'd4;
        end
    endtask

    always @(negedge clk) begin : mon
        int   held;
        ent_t e;
        if (rst_n) begin
            held = q.size() - int'(pend);
            chk("out_valid", 32'(out_valid), 32'(held > 0));
            chk("in_ready", 32'(in_ready), 32'(held < 2));
            chk("bubble_count", 32'(bubble_count), 32'(m_bub));
            chk("hold_count", 32'(hold_count), 32'(m_hold));
            if (held > 0) begin
                e = q[0];
                chk("pc_out", pc_out, e.pc);
                chk("pc_plus4_out", pc_plus4_out, e.pc + 32'd4);
                chk("instruction_out", instruction_out, e.ins);
                chk("pred_taken_out", 32'(pred_taken_out), 32'(e.pred));
                last_pc = e.pc;
            end else begin
                chk("empty_instr", instruction_out, NOP);
                chk("empty_pred", 32'(pred_taken_out), 32'd0);
                chk("empty_pc", pc_out, last_pc);
                chk("empty_pc4", pc_plus4_out, last_pc + 32'd4);
            end
            if (cnt_clear) begin
                m_bub  = 0;
                m_hold = 0;
            end else begin
                if (held == 0 && out_ready && m_bub < MAXC) m_bub++;
                if (held > 0 && !out_ready && m_hold < MAXC) m_hold++;
            end
            if (held > 0 && out_ready) void'(q.pop_front());
            if (flush) q.delete();
            pend = 1'b0;
        end
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0; cnt_clear = 1'b0;
        pc_in = '0; instruction_in = '0; pred_taken_in = 1'b0;
        next_pc = 32'h0;
        model_reset();
        #12;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_pc_out", pc_out, RPC);
        chk("rst_instr", instruction_out, NOP);
        chk("rst_pred", 32'(pred_taken_out), 32'd0);
        chk("rst_bubble", 32'(bubble_count), 32'd0);
        chk("rst_hold", 32'(hold_count), 32'd0);
        @(posedge clk); #2 rst_n = 1'b1;

        // In-order stream 0x00, 0x04, 0x08 at full rate.
        repeat (3) cyc(1, 1, 0, 0);
        repeat (3) cyc(0, 1, 0, 0);

        // Full-rate stream with a 3-cycle ID stall.
        cyc(0, 1, 0, 1);
        repeat (4) cyc(1, 1, 0, 0);
        repeat (3) cyc(1, 0, 0, 0);
        cyc(1, 1, 0, 0);
        chk("stall_hold_count", 32'(hold_count), 32'd3);
        repeat (4) cyc(1, 1, 0, 0);
        repeat (3) cyc(0, 1, 0, 0);

        // Flush while in TWO with a new entry offered.
        repeat (2) cyc(1, 0, 0, 0);
        cyc(1, 0, 1, 0);
        cyc(0, 0, 0, 0);
        chk("flush_out_valid", 32'(out_valid), 32'd0);
        chk("flush_in_ready", 32'(in_ready), 32'd1);
        chk("flush_instr", instruction_out, NOP);
        repeat (2) cyc(1, 1, 0, 0);
        repeat (2) cyc(0, 1, 0, 0);

        // PC wrap.
        next_pc = 32'hFFFF_FFFC;
        cyc(1, 0, 0, 0);
        cyc(0, 0, 0, 0);
        chk("wrap_pc4", pc_plus4_out, 32'h0000_0000);
        cyc(0, 1, 0, 0);

        // Bubble counter saturation and clear.
        cyc(0, 1, 0, 1);
        repeat (20) cyc(0, 1, 0, 0);
        cyc(0, 1, 0, 0);
        chk("bubble_sat", 32'(bubble_count), 32'(MAXC));
        cyc(0, 1, 0, 1);
        cyc(0, 0, 0, 0);
        chk("bubble_clear", 32'(bubble_count), 32'd0);

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 49) == 0) next_pc = $urandom & 32'hFFFF_FFFC;
            cyc(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0),
                1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 29) == 0));
        end

        // Asynchronous reset while in TWO.
        repeat (3) cyc(1, 0, 0, 0);
        @(posedge clk);
        #1 in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0; cnt_clear = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_in_ready", 32'(in_ready), 32'd1);
        chk("arst_pc_out", pc_out, RPC);
        chk("arst_instr", instruction_out, NOP);
        chk("arst_pred", 32'(pred_taken_out), 32'd0);
        chk("arst_hold", 32'(hold_count), 32'd0);
        model_reset();
        @(posedge clk); #2 rst_n = 1'b1;
        next_pc = 32'h0000_1000;
        repeat (2) cyc(1, 1, 0, 0);
        repeat (3) cyc(0, 1, 0, 0);
        chk("drain_empty", 32'(q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
